// File: rtl/sram_sp_masked_ext.sv
// Single-port SRAM model with per-lane write mask, optional output register and
// a clear sequencer that zeroes every entry after reset or on request.
module sram_sp_masked_ext #(
  parameter int DATA_WIDTH = 72,
  parameter int DEPTH      = 64,
  parameter int MASK_WIDTH = 8,
  parameter int OUT_REG    = 0,
  localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  RW0_clk,
  input  logic                  reset,
  input  logic                  RW0_en,
  input  logic                  RW0_wmode,
  input  logic [ADDR_WIDTH-1:0] RW0_addr,
  input  logic [DATA_WIDTH-1:0] RW0_wdata,
  input  logic [MASK_WIDTH-1:0] RW0_wmask,
  input  logic                  RW0_clear,
  output logic                  RW0_ready,
  output logic                  RW0_rvalid,
  output logic [DATA_WIDTH-1:0] RW0_rdata
);

  localparam int LW = DATA_WIDTH / MASK_WIDTH;

  typedef enum logic {ST_CLEAR, ST_READY} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] ram [DEPTH];

  logic                  in_range;
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [MASK_WIDTH-1:0] wlane;
  logic                  vld_p1_d, vld_p1_q;
  logic [DATA_WIDTH-1:0] rdata_p1_d, rdata_p1_q;

  assign RW0_ready = (state_q == ST_READY);
  assign in_range  = ({1'b0, RW0_addr} < (ADDR_WIDTH + 1)'(DEPTH));

  // The clear sequencer and user accesses share the single write port.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we         = 1'b0;
    waddr      = RW0_addr;
    wdata      = RW0_wdata;
    wlane      = RW0_wmask;
    vld_p1_d   = 1'b0;
    rdata_p1_d = rdata_p1_q;
    if (state_q == ST_CLEAR) begin
      we    = 1'b1;
      waddr = cnt_q;
      wdata = '0;
      wlane = '1;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
        state_d = ST_READY;
        cnt_d   = '0;
      end
    end else if (RW0_clear) begin
      state_d = ST_CLEAR;
      cnt_d   = '0;
    end else if (RW0_en) begin
      if (RW0_wmode) begin
        we = in_range;
      end else begin
        vld_p1_d   = 1'b1;
        rdata_p1_d = in_range ? ram[RW0_addr] : '0;
      end
    end
  end

  always_ff @(posedge RW0_clk) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      cnt_q      <= '0;
      vld_p1_q   <= 1'b0;
      rdata_p1_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      vld_p1_q   <= vld_p1_d;
      rdata_p1_q <= rdata_p1_d;
    end
  end

  always_ff @(posedge RW0_clk) begin
    if (we && !reset) begin
      for (int i = 0; i < MASK_WIDTH; i++) begin
        if (wlane[i]) ram[waddr][i*LW +: LW] <= wdata[i*LW +: LW];
      end
    end
  end

  // ---- optional output register stage ----
  generate
    if (OUT_REG != 0) begin : g_oreg
      logic                  vld_p2_q;
      logic [DATA_WIDTH-1:0] rdata_p2_d, rdata_p2_q;

      always_comb rdata_p2_d = vld_p1_q ? rdata_p1_q : rdata_p2_q;

      always_ff @(posedge RW0_clk) begin
        if (reset) begin
          vld_p2_q   <= 1'b0;
          rdata_p2_q <= '0;
        end else begin
          vld_p2_q   <= vld_p1_q;
          rdata_p2_q <= rdata_p2_d;
        end
      end

      assign RW0_rvalid = vld_p2_q;
      assign RW0_rdata  = rdata_p2_q;
    end else begin : g_noreg
      assign RW0_rvalid = vld_p1_q;
      assign RW0_rdata  = rdata_p1_q;
    end
  endgenerate

endmodule

// File: doc/sram_sp_masked_ext.md
Name: sram_sp_masked_ext

Overview:
Parametrised single-port SRAM behavioural model for sim-RTL. It is the successor to the fixed-size 1-RW macro models.
- Adds configurable depth and width, per-lane write mask, and an optional output pipeline stage.
- Adds a hardware clear sequencer that zeroes the array after reset or on request.
- Read data is deterministic (held, never random), so the same model serves both simulation and formal.

Parameters:
DATA_WIDTH, 72, bits per entry.
DEPTH, 64, number of entries; need not be a power of 2; must be >= 2.
MASK_WIDTH, 8, number of write lanes; DATA_WIDTH must be divisible by MASK_WIDTH; lane width LW = DATA_WIDTH/MASK_WIDTH.
OUT_REG, 0, 0: read latency 1; 1: read latency 2 (extra output register).
ADDR_WIDTH, clog2(DEPTH), address width, minimum 1; derived, not overridden.

Ports:
RW0_clk  input  1  clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
RW0_en  input  1  access enable.
RW0_wmode  input  1  1 = write, 0 = read (qualified by RW0_en).
RW0_addr  input  ADDR_WIDTH  entry address.
RW0_wdata  input  DATA_WIDTH  write data.
RW0_wmask  input  MASK_WIDTH  lane i writes bits [i*LW +: LW] when set.
RW0_clear  input  1  one-cycle request to re-zero the whole array.
RW0_ready  output  1  1 = accesses accepted; 0 = clear in progress.
RW0_rvalid  output  1  one-cycle pulse aligned with fresh RW0_rdata.
RW0_rdata  output  DATA_WIDTH  read data; holds last read value between reads.

Behaviour:
Reset:
- On reset: FSM = CLEAR, clear counter = 0, RW0_ready = 0, RW0_rvalid = 0, RW0_rdata = 0, pipeline valids = 0.
- Array contents are not reset directly; the CLEAR state zeroes them.
- Reset asserted at any time, including mid-CLEAR or mid-read, restarts CLEAR at address 0 and drops any in-flight read.

FSM states:
- CLEAR:
  - Each cycle writes all-zero to entry cnt; cnt increments.
  - After writing entry DEPTH-1, go to READY.
  - RW0_ready is 0 throughout, so RW0_ready rises exactly DEPTH cycles after the first posedge with reset low.
- READY:
  - RW0_ready = 1 and accesses are accepted.
  - RW0_clear = 1 → go to CLEAR with cnt = 0 next cycle; RW0_ready = 0 from that cycle.
  - RW0_clear is ignored while already in CLEAR.

Access rules (READY only):
- Accepted access = RW0_en & RW0_ready & !RW0_clear. RW0_clear has priority over a same-cycle access, and that access is dropped.
- Accesses while RW0_ready = 0 are silently dropped: no write, no rvalid.
- Write (wmode = 1): lanes with mask bit set are updated at the edge; unmasked lanes are unchanged. Mask 0 is a legal no-op.
- Read (wmode = 0), OUT_REG = 0:
  - Read issued in cycle T: RW0_rdata = ram[addr] and RW0_rvalid = 1 in cycle T+1.
- Read, OUT_REG = 1:
  - Same, but in cycle T+2.
  - The array value is sampled at the T edge, so a write in T+1 to the same address does not affect this read.
- Back-to-back reads give one result per cycle, in order.
- Read-after-write to the same address in the next cycle returns the new data.
- RW0_rdata changes only on rvalid cycles; otherwise it holds its value.
- Address out of range (addr >= DEPTH): the write is dropped; a read returns 0 with rvalid = 1.
- A clear request does not cancel an already-accepted read; that read completes with its pre-clear data.
- rvalid is never asserted from a dropped access.

Test Plan:
1. Reset 1 cycle, DEPTH = 64: RW0_ready is 0 for 64 cycles after reset release, then 1. Reading addresses 0, 31, 63 each returns 72'h0 with rvalid one cycle later.
2. Write addr 5, wdata all-ones, mask 8'h0F; read addr 5 next cycle → rdata = 72'h00_0000_000F_FFFF_FFFF. Then write wdata 0, mask 8'h01, read → 72'h00_0000_000F_FFFF_FE00.
3. OUT_REG = 1: write A to addr 7 and B to addr 8; reads of 7 and 8 issued back-to-back in T, T+1 → A at T+2, B at T+3, rvalid high both cycles, rdata holds B afterwards. Separately, read addr 7 at T with a write of C to addr 7 at T+1 → rdata = A at T+2.
4. In READY, pulse RW0_clear together with a write to addr 3 → write dropped, ready low for 64 cycles, all entries read as 0 afterwards. A read accepted the cycle before the clear still returns its old value.
5. Assert reset at clear cnt = 20 → clear restarts at 0; ready rises 64 cycles after reset release. A write attempted while ready = 0 leaves that entry 0.
6. DEPTH = 48: write to addr 50 is dropped; read addr 50 returns 0 with rvalid; addr 47 reads and writes normally.
